// File: rtl/ram_bus_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bridge_pkg : shared types and constants for ram_bus_bridge       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ram_bridge_pkg;

  localparam int RAM_WORDS    = 4096;
  localparam int RAM_AW       = 12;
  localparam int WINDOW_BYTES = 16384;

  // Rejection reason codes, reported by simulation messages only.
  localparam logic [1:0] ERR_RANGE       = 2'd0;
  localparam logic [1:0] ERR_ALIGN       = 2'd1;
  localparam logic [1:0] ERR_RW_CONFLICT = 2'd2;
  localparam logic [1:0] ERR_PARTIAL     = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RMW_RD   = 3'd4,
    RMW_WAIT = 3'd5,
    RMW_WR   = 3'd6,
    DONE     = 3'd7
  } state_e;

  function automatic logic is_partial(input logic [3:0] be);
    return (be != 4'h0) && (be != 4'hF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bus_bridge_if : CPU-side byte-addressed waitrequest memory bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ram_bus_bridge_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, bus_error
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, bus_error
  );

endinterface
`default_nettype wire

// File: rtl/ram_bus_bridge_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_lane_merge : per-lane select between old and new RAM words      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module byte_lane_merge (
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  byteenable_i,
  output logic [31:0] merged_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i +: 8] = byteenable_i[i] ? new_word_i[8*i +: 8]
                                                : old_word_i[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/ram_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bus_bridge : CPU memory bus to 32x4096 word RAM front end.       |
// | Define RAM_BRIDGE_RMW_EN to build read-modify-write partial stores.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_bus_bridge
  import ram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_bus_bridge_if.slave   bus,
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata
);

  state_e              state_q, state_d;
  logic [RAM_AW-1:0]   ram_address_q, ram_address_d;
  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [31:0]         ram_writedata_q, ram_writedata_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                bus_error_q, bus_error_d;

  logic [31:0]         w_off;
  logic                w_req;
  logic                w_reject;
  logic [RAM_AW-1:0]   w_word_idx;

  // Unsigned offset check also rejects addresses below BASE_ADDR via wrap.
  assign w_off      = bus.address - BASE_ADDR;
  assign w_word_idx = w_off[RAM_AW+1:2];
  assign w_req      = bus.read | bus.write;

`ifdef RAM_BRIDGE_RMW_EN
  logic [31:0] w_merged;

  byte_lane_merge u_merge (
    .old_word_i   (ram_readdata),
    .new_word_i   (bus.writedata),
    .byteenable_i (bus.byteenable),
    .merged_o     (w_merged)
  );

  assign w_reject = (w_off >= 32'(WINDOW_BYTES))
                  | (bus.address[1:0] != 2'b00)
                  | (bus.read & bus.write);
`else
  assign w_reject = (w_off >= 32'(WINDOW_BYTES))
                  | (bus.address[1:0] != 2'b00)
                  | (bus.read & bus.write)
                  | (bus.write & is_partial(bus.byteenable));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_reject) begin
            state_d = DONE;
          end else if (bus.read) begin
            state_d = RD;
          end else if (bus.byteenable == 4'hF) begin
            state_d = WR;
          end else if (bus.byteenable == 4'h0) begin
            state_d = DONE;
          end else begin
`ifdef RAM_BRIDGE_RMW_EN
            state_d = RMW_RD;
`else
            state_d = DONE;
`endif
          end
        end
      end
      RD:       state_d = RD_WAIT;
      RD_WAIT:  state_d = DONE;
      WR:       state_d = DONE;
`ifdef RAM_BRIDGE_RMW_EN
      RMW_RD:   state_d = RMW_WAIT;
      RMW_WAIT: state_d = RMW_WR;
      RMW_WR:   state_d = DONE;
`endif
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they fire in the first
  // cycle spent in RD/RMW_RD/WR/RMW_WR and nowhere else.
  always_comb begin
    ram_read_d      = (state_d == RD) || (state_d == RMW_RD);
    ram_write_d     = (state_d == WR) || (state_d == RMW_WR);
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    readdata_d      = readdata_q;
    bus_error_d     = bus_error_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_reject) begin
            readdata_d  = 32'h0;
            bus_error_d = 1'b1;
          end else begin
            ram_address_d = w_word_idx;
            if (state_d == WR) begin
              ram_writedata_d = bus.writedata;
            end
            if (state_d == DONE) begin
              bus_error_d = 1'b0;
            end
          end
        end
      end
      RD_WAIT: begin
        readdata_d  = ram_readdata;
        bus_error_d = 1'b0;
      end
      WR: begin
        bus_error_d = 1'b0;
      end
`ifdef RAM_BRIDGE_RMW_EN
      RMW_WAIT: begin
        ram_writedata_d = w_merged;
      end
      RMW_WR: begin
        bus_error_d = 1'b0;
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_address_q   <= '0;
      ram_read_q      <= 1'b0;
      ram_write_q     <= 1'b0;
      ram_writedata_q <= 32'h0;
      readdata_q      <= 32'h0;
      bus_error_q     <= 1'b0;
    end else begin
      ram_address_q   <= ram_address_d;
      ram_read_q      <= ram_read_d;
      ram_write_q     <= ram_write_d;
      ram_writedata_q <= ram_writedata_d;
      readdata_q      <= readdata_d;
      bus_error_q     <= bus_error_d;
    end
  end

  assign bus.waitrequest = w_req & (state_q != DONE);
  assign bus.readdata    = readdata_q;
  assign bus.bus_error   = bus_error_q;
  assign ram_address     = ram_address_q;
  assign ram_read        = ram_read_q;
  assign ram_write       = ram_write_q;
  assign ram_writedata   = ram_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_bus_bridge : directed self-checking bench for ram_bus_bridge  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ram_bus_bridge;
  import ram_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = 32'h0;

  ram_bus_bridge_if bus ();

  ram_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .ram_address   (ram_address),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  always #5 clk = ~clk;

  // Harness RAM: 1-cycle registered read, whole-word writes.
  logic [31:0] mem     [0:RAM_WORDS-1];
  logic [31:0] ref_mem [0:RAM_WORDS-1];

  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_writedata;
    if (ram_read)  ram_readdata     <= mem[ram_address];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of the current transaction, written by the driver.
  int          exp_lat;
  logic        exp_err;
  logic [1:0]  exp_reason;
  logic        exp_chk_rdata;
  logic [31:0] exp_rdata;
  int          exp_nrd, exp_nwr;
  logic        txn_active = 1'b0;

  // Owned by the compare process.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic txn_done = 1'b0;

  task automatic compute_expect(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] off;
    logic [31:0] nw;
    int          idx;
    off = addr - BASE;
    idx = int'(off >> 2) % RAM_WORDS;
    exp_err = 1'b0; exp_reason = ERR_RANGE; exp_chk_rdata = 1'b0;
    exp_rdata = 32'h0; exp_nrd = 0; exp_nwr = 0;
    if (off >= 32'd16384)          begin exp_err = 1'b1; exp_reason = ERR_RANGE; end
    else if (addr[1:0] != 2'b00)   begin exp_err = 1'b1; exp_reason = ERR_ALIGN; end
    else if (rd && wr)             begin exp_err = 1'b1; exp_reason = ERR_RW_CONFLICT; end
`ifndef RAM_BRIDGE_RMW_EN
    else if (wr && be != 4'h0 && be != 4'hF) begin exp_err = 1'b1; exp_reason = ERR_PARTIAL; end
`endif
    if (exp_err) begin
      exp_lat = 1; exp_chk_rdata = 1'b1; exp_rdata = 32'h0;
    end else if (rd) begin
      exp_lat = 3; exp_nrd = 1; exp_chk_rdata = 1'b1; exp_rdata = ref_mem[idx];
    end else if (be == 4'hF) begin
      exp_lat = 2; exp_nwr = 1; ref_mem[idx] = wd;
    end else if (be == 4'h0) begin
      exp_lat = 1;
    end else begin
      exp_lat = 4; exp_nrd = 1; exp_nwr = 1;
      nw = ref_mem[idx];
      for (int l = 0; l < 4; l++) if (be[l]) nw[8*l +: 8] = wd[8*l +: 8];
      ref_mem[idx] = nw;
    end
  endtask

  always @(negedge clk) begin
    if (!txn_active) begin
      cyc = 0; rd_cnt = 0; wr_cnt = 0; txn_done = 1'b0;
    end else if (!txn_done) begin
      check("waitrequest", {31'b0, bus.waitrequest}, {31'b0, cyc != exp_lat});
      check("strobe_overlap", {31'b0, ram_read & ram_write}, 32'h0);
      rd_cnt += int'(ram_read);
      wr_cnt += int'(ram_write);
      if (!bus.waitrequest) begin
        check($sformatf("bus_error(reason %0d)", exp_reason), {31'b0, bus.bus_error}, {31'b0, exp_err});
        if (exp_chk_rdata) check("readdata", bus.readdata, exp_rdata);
        check("ram_read_pulses", rd_cnt, exp_nrd);
        check("ram_write_pulses", wr_cnt, exp_nwr);
        txn_done = 1'b1;
      end else if (cyc >= 8) begin
        check("completion_timeout", 32'(cyc), 32'(exp_lat));
        txn_done = 1'b1;
      end
      cyc++;
    end
  end

  task automatic drop_request();
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 32'h0;
    bus.byteenable = 4'h0; bus.writedata = 32'h0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12 && !txn_done; i++) @(posedge clk);
    if (!txn_done) check("txn_not_done", 32'h0, 32'h1);
    #1;
    drop_request();
    txn_active = 1'b0;
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    compute_expect(rd, wr, addr, be, wd);
    @(posedge clk); #1;
    bus.read = rd; bus.write = wr; bus.address = addr;
    bus.byteenable = be; bus.writedata = wd;
    txn_active = 1'b1;
    wait_done();
  endtask

  initial begin
    drop_request();
    for (int i = 0; i < RAM_WORDS; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    mem[0] = 32'h01020304; ref_mem[0] = 32'h01020304;
    mem[3] = 32'hAABBCCDD; ref_mem[3] = 32'hAABBCCDD;
    mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_waitrequest", {31'b0, bus.waitrequest}, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_bus_error", {31'b0, bus.bus_error}, 32'h0);
    check("rst_ram_address", {20'b0, ram_address}, 32'h0);
    check("rst_ram_strobes", {30'b0, ram_read, ram_write}, 32'h0);
    check("rst_ram_writedata", ram_writedata, 32'h0);

    // Read of preloaded word 5.
    do_txn(1'b1, 1'b0, BASE + 32'd20, 4'h0, 32'h0);
    check("read_w5_literal", bus.readdata, 32'hDEADBEEF);

    // Full write then read-back.
    do_txn(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h12345678);
    check("mem_w2", mem[2], 32'h12345678);
    do_txn(1'b1, 1'b0, BASE + 32'd8, 4'h3, 32'h0);
    check("readback_w2_literal", bus.readdata, 32'h12345678);

    // Partial write into word 3.
    do_txn(1'b0, 1'b1, BASE + 32'd12, 4'b0101, 32'h11223344);
`ifdef RAM_BRIDGE_RMW_EN
    check("mem_w3_merged", mem[3], 32'hAA22CC44);
`else
    check("mem_w3_kept", mem[3], 32'hAABBCCDD);
`endif

    // Rejections: out of window, misaligned, read+write, below base.
    do_txn(1'b1, 1'b0, BASE + 32'd16384, 4'hF, 32'h0);
    do_txn(1'b1, 1'b0, BASE + 32'd2, 4'hF, 32'h0);
    do_txn(1'b1, 1'b1, BASE, 4'hF, 32'hFFFFFFFF);
    do_txn(1'b0, 1'b1, BASE - 32'd4, 4'hF, 32'hFFFFFFFF);
    check("mem_w0_untouched", mem[0], 32'h01020304);

    // Top word of the window, no wrap to word 0.
    do_txn(1'b0, 1'b1, BASE + 32'd16380, 4'hF, 32'hCAFEF00D);
    do_txn(1'b1, 1'b0, BASE + 32'd16380, 4'hF, 32'h0);
    check("mem_w4095", mem[4095], 32'hCAFEF00D);
    check("mem_w0_no_wrap", mem[0], 32'h01020304);

    // Empty write: completes at cycle 1, no strobe, no error.
    do_txn(1'b0, 1'b1, BASE + 32'd40, 4'h0, 32'h99999999);
    check("mem_w10_empty", mem[10], 32'h0);

    // Reset in the middle of a held write to word 3.
    @(posedge clk); #1;
    bus.write = 1'b1; bus.address = BASE + 32'd12; bus.writedata = 32'h55667788;
`ifdef RAM_BRIDGE_RMW_EN
    bus.byteenable = 4'b1010;
    repeat (2) @(posedge clk);
`else
    bus.byteenable = 4'hF;
    repeat (1) @(posedge clk);
`endif
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_ram_read", {31'b0, ram_read}, 32'h0);
    check("rst_mid_ram_write", {31'b0, ram_write}, 32'h0);
    repeat (2) @(posedge clk);
`ifdef RAM_BRIDGE_RMW_EN
    check("rst_mid_w3_unchanged", mem[3], 32'hAA22CC44);
`else
    check("rst_mid_w3_unchanged", mem[3], 32'hAABBCCDD);
`endif
    compute_expect(1'b0, 1'b1, bus.address, bus.byteenable, bus.writedata);
    #1;
    reset_n = 1'b1;
    txn_active = 1'b1;
    wait_done();
`ifdef RAM_BRIDGE_RMW_EN
    check("restart_w3", mem[3], 32'h55227744);
`else
    check("restart_w3", mem[3], 32'h55667788);
`endif
    do_txn(1'b1, 1'b0, BASE + 32'd12, 4'h0, 32'h0);

    for (int i = 0; i < RAM_WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
    end
    check("final_mem_w5", mem[5], ref_mem[5]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bus_bridge.md
# ram_bus_bridge

Bus-side front end for the 32x4096 word RAM: accepts CPU data/instruction accesses on a byte-addressed, byte-enabled, waitrequest-stalled memory bus and turns them into single-word accesses on the RAM's 12-bit word-addressed port. The RAM has a 1-cycle registered read and no byte enables. This block therefore handles address translation and range checks, and performs read-modify-write for partial stores. It sits between the CPU bus master and the RAM instance in the test harness.

## Interface
Parameters:
- BASE_ADDR, 32'hBFC0_0000, byte address mapped to RAM word 0; window size is 16 KiB.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  32  CPU byte address
- read  in  1  CPU read request, held until waitrequest low
- write  in  1  CPU write request, held until waitrequest low
- byteenable  in  4  lane enables, bit i = writedata[8i+7:8i]
- writedata  in  32  CPU store data
- waitrequest  out  1  stall; low for exactly one cycle on completion
- readdata  out  32  load data, valid in the completion cycle
- bus_error  out  1  high in the completion cycle of a rejected access
- ram_address  out  12  RAM word index (registered)
- ram_read  out  1  RAM read strobe (registered)
- ram_write  out  1  RAM write strobe (registered)
- ram_writedata  out  32  RAM store data (registered)
- ram_readdata  in  32  RAM data, valid the cycle after ram_read

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, DONE.
- Word index: (address - BASE_ADDR) >> 2, truncated to 12 bits.
- Rejected access, taking IDLE → DONE with bus_error=1, readdata=0 and no RAM strobe, when any of these hold:
  - address outside [BASE_ADDR, BASE_ADDR+16383];
  - address[1:0] != 0;
  - read and write both high.
- Read: IDLE→RD (drive ram_read, ram_address)→RD_WAIT (capture ram_readdata into readdata)→DONE.
- Full write (byteenable=4'hF): IDLE→WR (ram_write, ram_writedata=writedata)→DONE.
- Partial write (byteenable 1..E):
  - IDLE→RMW_RD→RMW_WAIT: capture the old word.
  - RMW_WR: ram_writedata = enabled lanes from writedata, other lanes from the old word.
  - RMW_WR→DONE.
- Write with byteenable=0: IDLE→DONE, no RAM access, no error.
- Read ignores byteenable and always returns the full word.
- DONE→IDLE unconditionally. A request still held in IDLE is treated as a new access.
- ram_read and ram_write are never high together and are high only in the cycle after entering RD/RMW_RD/WR/RMW_WR (one cycle each).

## Timing
- waitrequest = (read | write) & (state != DONE), combinational. It is low when idle with no request.
- Completion cycle (waitrequest low), counted from the first request cycle (cycle 0):
  - read: cycle 3;
  - full write: cycle 2;
  - partial write: cycle 4;
  - rejected or empty write: cycle 1.
- readdata and bus_error hold their values until the next completion. bus_error clears on the next non-error completion.
- Reset values: state=IDLE, readdata=0, bus_error=0, ram_address=0, ram_read=0, ram_write=0, ram_writedata=0.
- Reset mid-operation:
  - Strobes drop immediately (async) and the in-flight access is abandoned.
  - A partial RMW never writes a half-merged word.
  - The master's still-held request restarts from IDLE after reset_n rises.

## Configuration
- RAM_BRIDGE_RMW_EN defined: partial writes use the RMW sequence above.
- RAM_BRIDGE_RMW_EN undefined:
  - RMW_RD, RMW_WAIT and RMW_WR are not built.
  - Partial writes (byteenable 1..E) are rejected: IDLE→DONE, bus_error=1, no RAM write.
  - Full and empty writes are unchanged.

## Structure
- Package ram_bridge_pkg:
  - state enum type;
  - RAM_WORDS=4096, RAM_AW=12, WINDOW_BYTES=16384;
  - ERR_* reason constants (range, align, rw_conflict, partial), used for sim messages.
- Sub-module byte_lane_merge:
  - combinational;
  - inputs: old word, new word, byteenable;
  - output: merged word.
  - Instantiated only under RAM_BRIDGE_RMW_EN.

## Test plan
- Read: preload word 5 = 32'hDEADBEEF; read at BASE_ADDR+20 → waitrequest low at cycle 3, readdata=32'hDEADBEEF, bus_error=0, exactly one ram_read pulse.
- Full write: write 32'h12345678 at BASE_ADDR+8 with be=F, then read it back → completion at cycle 2, word 2 = 32'h12345678, no ram_read during the write.
- Partial write: word 3 = 32'hAABBCCDD; write 32'h11223344 with be=4'b0101 → word 3 = 32'hAA22CC44, completion at cycle 4. With the macro undefined: bus_error=1 and word 3 unchanged.
- Rejections: each of the following completes at cycle 1 with bus_error=1, readdata=0 and no RAM strobe:
  - address BASE_ADDR+16384;
  - address BASE_ADDR+2;
  - read and write both high.
- Boundary: write then read at BASE_ADDR+16380 → word 4095 accessed, no wrap to word 0. Write with be=0 → completion at cycle 1, no strobe, bus_error=0.
- Reset: assert reset_n=0 in the RMW_WAIT state → strobes drop immediately, the target word is unchanged, and the held request completes normally after release.
